// File: rtl/act_s2_tile.sv
// act_s2_tile
//   Array of CH registered ACT-S2-style logic cells. Each channel forms two
//   select terms S0/S1 from its operands (gating chosen by a per-channel
//   run-time mode), picks one of four BITS-wide data words, and registers it.
//   Modes are loaded one word per channel through a ready/valid port into a
//   shadow set, and the shadow set is copied to the active set in one cycle.
//
//   Optional feature: define ACT_S2_TILE_PIPE_EN to add a second output
//   register stage (2-cycle data latency, out_valid delayed to match).
//
// Ports
//   clk_i            rising-edge clock
//   rst_ni           asynchronous active-low reset
//   en_i             capture enable for all channel registers
//   d00_i..d11_i     CH*BITS data words, channel i at [i*BITS +: BITS]
//   a0_i,b0_i,a1_i,b1_i  CH select operands, bit i -> channel i
//   cfg_valid_i      configuration word valid
//   cfg_data_i       2-bit mode word for the next channel in sequence
//   cfg_ready_o      tile accepts a configuration word
//   cfg_done_o       one-cycle pulse while the new mode set is committed
//   out_o            registered channel outputs, same packing as d*_i
//   out_valid_o      qualifies out_o (registered copy of en_i)
module act_s2_tile #(
  parameter int BITS = 2,
  parameter int CH   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [CH*BITS-1:0]   d00_i,
  input  logic [CH*BITS-1:0]   d01_i,
  input  logic [CH*BITS-1:0]   d10_i,
  input  logic [CH*BITS-1:0]   d11_i,
  input  logic [CH-1:0]        a0_i,
  input  logic [CH-1:0]        b0_i,
  input  logic [CH-1:0]        a1_i,
  input  logic [CH-1:0]        b1_i,
  input  logic                 cfg_valid_i,
  input  logic [1:0]           cfg_data_i,
  output logic                 cfg_ready_o,
  output logic                 cfg_done_o,
  output logic [CH*BITS-1:0]   out_o,
  output logic                 out_valid_o
);

  localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CH-1:0][1:0]        shadow_q, shadow_d;
  logic [CH-1:0][1:0]        mode_q, mode_d;
  logic                      hs;

  logic [CH-1:0][BITS-1:0]   sel_w;
  logic [CH-1:0][BITS-1:0]   out_p1_q;
  logic                      vld_p1_q;

  // Mode 3 never reaches this mux: the capture enable blocks it instead.
  function automatic logic [BITS-1:0] cell_sel(
    input logic [1:0]      mode,
    input logic            a0,
    input logic            b0,
    input logic            a1,
    input logic            b1,
    input logic [BITS-1:0] w00,
    input logic [BITS-1:0] w01,
    input logic [BITS-1:0] w10,
    input logic [BITS-1:0] w11
  );
    logic s0, s1;
    case (mode)
      2'd0:    begin s0 = a0 & b0; s1 = a1 | b1; end
      2'd1:    begin s0 = a0 | b0; s1 = a1 & b1; end
      default: begin s0 = a0;      s1 = a1;      end
    endcase
    case ({s0, s1})
      2'b00:   cell_sel = w00;
      2'b01:   cell_sel = w01;
      2'b10:   cell_sel = w10;
      default: cell_sel = w11;
    endcase
  endfunction

  // ---------------- configuration FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // ---------------- configuration FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (hs) state_d = (idx_q == IDX_LAST) ? S_COMMIT : S_LOAD;
      S_LOAD:   if (hs && (idx_q == IDX_LAST)) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- configuration FSM: outputs
  always_comb begin
    cfg_ready_o = (state_q != S_COMMIT);
    cfg_done_o  = (state_q == S_COMMIT);
  end

  assign hs = cfg_valid_i & cfg_ready_o;

  // Shadow writes, index stepping and the atomic commit copy.
  always_comb begin
    idx_d    = idx_q;
    shadow_d = shadow_q;
    mode_d   = mode_q;
    if (hs) begin
      shadow_d[idx_q] = cfg_data_i;
      if (idx_q != IDX_LAST) idx_d = idx_q + 1'b1;
    end
    if (state_q == S_COMMIT) begin
      mode_d = shadow_q;
      idx_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q    <= '0;
      shadow_q <= '0;
      mode_q   <= '0;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      mode_q   <= mode_d;
    end
  end

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      sel_w[i] = cell_sel(mode_q[i], a0_i[i], b0_i[i], a1_i[i], b1_i[i],
                          d00_i[i*BITS +: BITS], d01_i[i*BITS +: BITS],
                          d10_i[i*BITS +: BITS], d11_i[i*BITS +: BITS]);
    end
  end

  // ---------------- stage 1: channel registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_p1_q <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (en_i && (mode_q[i] != 2'd3)) out_p1_q[i] <= sel_w[i];
      end
      vld_p1_q <= en_i;
    end
  end

`ifdef ACT_S2_TILE_PIPE_EN
  logic [CH-1:0][BITS-1:0] out_p2_q;
  logic                    vld_p2_q;

  // ---------------- stage 2: free-running output register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_p2_q <= '0;
      vld_p2_q <= 1'b0;
    end else begin
      out_p2_q <= out_p1_q;
      vld_p2_q <= vld_p1_q;
    end
  end

  assign out_o       = out_p2_q;
  assign out_valid_o = vld_p2_q;
`else
  assign out_o       = out_p1_q;
  assign out_valid_o = vld_p1_q;
`endif

endmodule

// File: tb/tb_act_s2_tile.sv
module tb_act_s2_tile;

`ifdef ACT_S2_TILE_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       en_i;
  logic [7:0] d00_i, d01_i, d10_i, d11_i;
  logic [3:0] a0_i, b0_i, a1_i, b1_i;
  logic       cfg_valid_i;
  logic [1:0] cfg_data_i;
  logic       cfg_ready_o, cfg_done_o;
  logic [7:0] out_o;
  logic       out_valid_o;

  int errors = 0;
  int checks = 0;

  act_s2_tile #(.BITS(2), .CH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
    .d00_i(d00_i), .d01_i(d01_i), .d10_i(d10_i), .d11_i(d11_i),
    .a0_i(a0_i), .b0_i(b0_i), .a1_i(a1_i), .b1_i(b1_i),
    .cfg_valid_i(cfg_valid_i), .cfg_data_i(cfg_data_i),
    .cfg_ready_o(cfg_ready_o), .cfg_done_o(cfg_done_o),
    .out_o(out_o), .out_valid_o(out_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [1:0] words [4];

  initial begin
    // All channels share the same word pattern: d00=0, d01=1, d10=2, d11=3.
    rst_ni = 1'b0; en_i = 1'b0; cfg_valid_i = 1'b0; cfg_data_i = 2'd0;
    d00_i = 8'h00; d01_i = 8'h55; d10_i = 8'hAA; d11_i = 8'hFF;
    a0_i = 4'h0; b0_i = 4'h0; a1_i = 4'h0; b1_i = 4'h0;
    tick(); tick();
    chk("rst_out", 32'(out_o), 32'h00);
    chk("rst_valid", 32'(out_valid_o), 32'h0);
    chk("rst_done", 32'(cfg_done_o), 32'h0);
    chk("rst_ready", 32'(cfg_ready_o), 32'h1);
    rst_ni = 1'b1;

    // Reset defaults: mode 0, S0=1&1, S1=0|0 -> d10 = 2 on every channel
    a0_i = 4'hF; b0_i = 4'hF; a1_i = 4'h0; b1_i = 4'h0; en_i = 1'b1;
    tick();
`ifdef ACT_S2_TILE_PIPE_EN
    chk("pipe_out_edge1", 32'(out_o), 32'h00);
    chk("pipe_valid_edge1", 32'(out_valid_o), 32'h0);
    tick();
`endif
    chk("dflt_ch0", 32'(out_o[1:0]), 32'h2);
    chk("dflt_out", 32'(out_o), 32'hAA);
    chk("dflt_valid", 32'(out_valid_o), 32'h1);

    // Full mode load {1,2,3,0}, en low so outputs stay at AA
    en_i = 1'b0;
    words[0] = 2'd1; words[1] = 2'd2; words[2] = 2'd3; words[3] = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cfg_valid_i = 1'b1; cfg_data_i = words[k];
      chk($sformatf("load_ready%0d", k), 32'(cfg_ready_o), 32'h1);
      chk($sformatf("load_done%0d", k), 32'(cfg_done_o), 32'h0);
      tick();
    end
    // COMMIT: a word offered here must not be taken
    cfg_data_i = 2'd3;
    chk("commit_ready", 32'(cfg_ready_o), 32'h0);
    chk("commit_done", 32'(cfg_done_o), 32'h1);
    tick();
    cfg_valid_i = 1'b0;
    chk("post_commit_ready", 32'(cfg_ready_o), 32'h1);
    chk("post_commit_done", 32'(cfg_done_o), 32'h0);
    // ch0 m1 -> d11, ch1 m2 -> d11, ch2 hold 2, ch3 m0 -> d01: 01_10_11_11
    a0_i = 4'hF; b0_i = 4'h0; a1_i = 4'hF; b1_i = 4'hF; en_i = 1'b1;
    repeat (LAT) tick();
    chk("modes_out", 32'(out_o), 32'h6F);

    // Mode isolation: load {0,0,0,0} with gaps while toggling en
    for (int k = 0; k < 3; k++) begin
      cfg_valid_i = 1'b1; cfg_data_i = 2'd0; en_i = k[0];
      tick();
      cfg_valid_i = 1'b0;
      tick();
      chk($sformatf("iso_ready%0d", k), 32'(cfg_ready_o), 32'h1);
      en_i = ~en_i;
      tick();
      chk($sformatf("iso_out%0d", k), 32'(out_o), 32'h6F);
    end
    cfg_valid_i = 1'b1; cfg_data_i = 2'd0; en_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    chk("iso_commit_done", 32'(cfg_done_o), 32'h1);
    tick();
    chk("iso_commit_edge_out", 32'(out_o), 32'h6F);
    repeat (LAT) tick();
    chk("iso_new_out", 32'(out_o), 32'h55);

    // Enable low while data changes
    en_i = 1'b0;
    repeat (LAT) tick();
    for (int k = 0; k < 5; k++) begin
      d00_i = 8'($urandom); d01_i = 8'($urandom);
      d10_i = 8'($urandom); d11_i = 8'($urandom);
      tick();
      chk($sformatf("enlow_out%0d", k), 32'(out_o), 32'h55);
      chk($sformatf("enlow_valid%0d", k), 32'(out_valid_o), 32'h0);
    end
    d00_i = 8'h00; d01_i = 8'h55; d10_i = 8'hAA; d11_i = 8'hFF;

    // Reset mid-load after two words of 3
    for (int k = 0; k < 2; k++) begin
      cfg_valid_i = 1'b1; cfg_data_i = 2'd3;
      tick();
    end
    cfg_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("midrst_ready", 32'(cfg_ready_o), 32'h1);
    chk("midrst_out", 32'(out_o), 32'h00);
    tick();
    rst_ni = 1'b1;
    // All modes back to 0: S0=1&0, S1=1|1 -> d01
    en_i = 1'b1;
    repeat (LAT) tick();
    chk("midrst_mode0_out", 32'(out_o), 32'h55);

    // Reload {2,2,2,2} back to back
    for (int k = 0; k < 4; k++) begin
      cfg_valid_i = 1'b1; cfg_data_i = 2'd2;
      tick();
    end
    cfg_valid_i = 1'b0;
    chk("reload_done", 32'(cfg_done_o), 32'h1);
    chk("reload_ready", 32'(cfg_ready_o), 32'h0);
    tick();
    chk("reload_done_clear", 32'(cfg_done_o), 32'h0);
    // Plain mux per channel: {a0,a1} = ch0 11, ch1 01, ch2 10, ch3 00
    a0_i = 4'b0101; a1_i = 4'b0011; b0_i = 4'h0; b1_i = 4'h0;
    repeat (LAT) tick();
    chk("mux_out", 32'(out_o), 32'h27);
    chk("mux_valid", 32'(out_valid_o), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
